dcache_mem_port: RTL and testbench

DCACHE_MEM_PORT -- requirements
Module: dcache_mem_port

---
 rtl/dcache_mem_port.sv | 107 ++++++++++
 tb/tb_dcache_mem_port.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_port.sv
// dcache_mem_port
// Fixed-latency backing memory for the data cache. It serves one 256-bit line
// per transaction. A request is captured in IDLE. The port then waits LATENCY
// cycles in BUSY, performs the access and pulses ack_o for one cycle in ACK.
//
// Ports
//   clk_i     clock; all state changes on the rising edge
//   rst_i     asynchronous active-low reset
//   addr_i    byte address; bits [4:0] ignored, bits above the array wrap
//   data_i    write line
//   enable_i  request valid (sampled only in IDLE)
//   write_i   1 = line write, 0 = line read
//   data_o    last line read; held across writes and idle cycles
//   ack_o     one-cycle completion pulse
//   busy_o    high while a transaction is outstanding (BUSY and ACK)
module dcache_mem_port #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic [255:0] data_o,
    output logic         ack_o,
    output logic         busy_o
);

    localparam int         LINES = 1 << DEPTH_LOG2;
    localparam logic [5:0] LAT   = 6'(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                  state;
    logic [5:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   line_q;
    logic [255:0]            wdata_q;
    logic                    we_q;
    logic [255:0]            mem [0:LINES-1];
    logic                    access;

    // Offset bits and bits above the array are ignored by design.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

    // The access edge is the BUSY edge on which the counter has reached
    // LATENCY. Reset forces IDLE asynchronously, so a transaction that is
    // interrupted by reset never writes the array.
    assign access = (state == BUSY) && (cnt_q == LAT);

    // The array has no reset. Its contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (access && we_q)
            mem[line_q] <= wdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            data_o  <= '0;
            ack_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        line_q  <= addr_i[DEPTH_LOG2+4:5];
                        wdata_q <= data_i;
                        we_q    <= write_i;
                        cnt_q   <= 6'd1;
                        busy_o  <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (access) begin
                        if (!we_q)
                            data_o <= mem[line_q];
                        ack_o <= 1'b1;
                        state <= ACK;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                ACK: begin
                    // The port always returns to IDLE, so a request held
                    // across ACK is taken on the following edge.
                    ack_o  <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    ack_o  <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_mem_port.sv
// tb_dcache_mem_port
// Scoreboard bench for dcache_mem_port (LATENCY=10, DEPTH_LOG2=9), plus a
// second instance with LATENCY=1 for minimum latency and address wrap.
// The model is a line array plus the rule that a request accepted at edge k
// acks at edge k+LATENCY. The port can accept again at edge k+LATENCY+2.
module tb_dcache_mem_port;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [31:0]  addr;
    logic [255:0] data;
    logic         enable, write;
    logic [255:0] dout;
    logic         ack, busy;

    logic [31:0]  addr1;
    logic [255:0] data1;
    logic         enable1, write1;
    logic [255:0] dout1;
    logic         ack1, busy1;

    always #5 clk = ~clk;

    dcache_mem_port #(.LATENCY(LAT), .DEPTH_LOG2(9)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(data),
        .enable_i(enable), .write_i(write),
        .data_o(dout), .ack_o(ack), .busy_o(busy)
    );

    dcache_mem_port #(.LATENCY(1), .DEPTH_LOG2(9)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr1), .data_i(data1),
        .enable_i(enable1), .write_i(write1),
        .data_o(dout1), .ack_o(ack1), .busy_o(busy1)
    );

    typedef struct {
        bit           we;
        int           acc;
        logic [255:0] data;
    } exp_t;

    exp_t         q[$];
    logic [255:0] model [512];
    int           kl[$];
    logic [255:0] exp_dout = '0;
    int           cyc = 0;
    int           next_free = 0;
    int           nvec = 0;
    int           nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: compares ack/busy/data_o every cycle and pops on each ack.
    always @(negedge clk) begin
        bit   exp_ack, exp_busy;
        exp_t e;
        #1;
        exp_busy = (q.size() > 0);
        exp_ack  = (q.size() > 0) && (cyc == q[0].acc + LAT);
        chk("ack_o", 256'(ack), 256'(exp_ack));
        chk("busy_o", 256'(busy), 256'(exp_busy));
        if (ack) begin
            if (q.size() == 0) begin
                chk("ack_unexpected", 256'(1), 256'(0));
            end else begin
                e = q.pop_front();
                chk("ack_latency", 256'(cyc - e.acc), 256'(LAT));
                if (!e.we) exp_dout = e.data;
            end
        end
        chk("data_o", dout, exp_dout);
    end

    // Issue one request. It returns at the negedge after the accepting edge
    // with enable still high. upd=0 leaves the model untouched (reset test).
    task automatic issue(input bit we, input logic [31:0] a, input logic [255:0] d, input bit upd);
        int   tgt;
        int   ln;
        exp_t e;
        while (cyc + 2 < next_free) @(negedge clk);
        enable = 1'b1; write = we; addr = a; data = d;
        tgt = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        while (cyc < tgt) @(negedge clk);
        ln = int'(a[13:5]);
        if (we && upd) begin
            model[ln] = d;
            if (!(ln inside {kl})) kl.push_back(ln);
        end
        e.we = we; e.acc = cyc; e.data = we ? '0 : model[ln];
        q.push_back(e);
        next_free = cyc + LAT + 2;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Random input churn while the transaction is in BUSY/ACK.
    task automatic churn();
        while (cyc + 2 < next_free) begin
            enable = 1'($urandom); write = 1'($urandom);
            addr = $urandom; data = rnd256();
            @(negedge clk);
        end
    endtask

    initial begin
        logic [255:0] d;
        logic [31:0]  a;
        int           ln;
        int           acc7;
        enable = 0; write = 0; addr = '0; data = '0;
        enable1 = 0; write1 = 0; addr1 = '0; data1 = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload line 3, then read it back and hold it for 20 idle cycles.
        issue(1, 32'h0000_0060, {8{32'hA5A5_0003}}, 1);
        idle(3);
        issue(0, 32'h0000_0060, '0, 1);
        idle(LAT + 20);

        // Write then read; data_o must not move during the write.
        issue(1, 32'h0000_0400, {8{32'hDEAD_BEEF}}, 1);
        idle(2);
        issue(0, 32'h0000_0400, '0, 1);
        idle(LAT + 3);

        // Writeback immediately followed by refill of the aliasing line 1.
        d = rnd256();
        issue(1, 32'h0000_0020, d, 1);
        issue(0, 32'h0000_4020, '0, 1);
        idle(LAT + 3);

        // Input churn during BUSY.
        issue(0, 32'h0000_0400, '0, 1);
        churn();
        idle(2);

        // Randomized traffic with churn and idle gaps.
        for (int t = 0; t < 60; t++) begin
            if (kl.size() < 4 || $urandom_range(0, 1) == 0) begin
                ln = $urandom_range(0, 511);
                a = $urandom; a[13:5] = 9'(ln);
                issue(1, a, rnd256(), 1);
            end else begin
                ln = kl[$urandom_range(0, kl.size() - 1)];
                a = $urandom; a[13:5] = 9'(ln);
                issue(0, a, '0, 1);
            end
            if ($urandom_range(0, 1) == 1) churn();
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        idle(LAT + 3);

        // Reset in the middle of a write to line 7 (counter = 5).
        issue(1, 32'h0000_00E0, {8{32'h0000_0777}}, 1);
        idle(LAT + 2);
        issue(1, 32'h0000_00E0, {8{32'hBAD0_BAD0}}, 0);
        acc7 = q[q.size() - 1].acc;
        enable = 1'b0;
        while (cyc < acc7 + 4) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        exp_dout = '0;
        next_free = 0;
        #1;
        chk("rst_ack", 256'(ack), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_data", dout, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 32'h0000_00E0, '0, 1);
        idle(LAT + 3);
        chk("drain", 256'(q.size()), 256'(0));

        // LATENCY=1 instance: wrap-around and minimum latency.
        d = rnd256();
        enable1 = 1; write1 = 1; addr1 = 32'h0000_4000; data1 = d;
        @(negedge clk);
        enable1 = 0;
        chk("l1_wr_busy", 256'(busy1), 256'(1));
        chk("l1_wr_noack", 256'(ack1), 256'(0));
        @(negedge clk);
        chk("l1_wr_ack", 256'(ack1), 256'(1));
        @(negedge clk);
        chk("l1_wr_ackfall", 256'(ack1), 256'(0));
        chk("l1_wr_idle", 256'(busy1), 256'(0));
        chk("l1_wr_dout", dout1, '0);
        enable1 = 1; write1 = 0; addr1 = 32'h0000_0000;
        @(negedge clk);
        enable1 = 0;
        chk("l1_rd_noack", 256'(ack1), 256'(0));
        @(negedge clk);
        chk("l1_rd_ack", 256'(ack1), 256'(1));
        chk("l1_rd_wrap", dout1, d);
        @(negedge clk);
        chk("l1_rd_ackfall", 256'(ack1), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
